// File: rtl/bimodal_branch_predictor_pkg.sv
// rtl/bimodal_branch_predictor_pkg.sv - shared sizing helper for the bimodal predictor
//
// Purpose: counter-width helper used by the predictor top and its counter cells.
// Ports:   none (package).
package bimodal_branch_predictor_pkg;

  // Bits needed to hold a counter with 'states' states; never narrower than 1 bit.
  function automatic int cnt_width(input int states);
    return (states < 2) ? 1 : $clog2(states);
  endfunction

endpackage

// File: rtl/bimodal_branch_predictor_sat_counter.sv
// rtl/bimodal_branch_predictor_sat_counter.sv - one saturating up/down counter of the table
//
// Purpose: holds one table entry. It moves one step up or down and saturates at 0 and WIDTH-1.
// Ports:
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset; the entry loads RESET
//   increment_i  step up unless already at WIDTH-1
//   decrement_i  step down unless already at 0
//   count_o      current counter value
module bimodal_branch_predictor_sat_counter
  import bimodal_branch_predictor_pkg::*;
#(
  parameter int WIDTH = 4,  // number of counter states
  parameter int RESET = 1,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          increment_i,
  input  logic          decrement_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MIN   = '0;
  localparam logic [CW-1:0] CNT_RESET = CW'(RESET);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (increment_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else if (decrement_i && (count_q != CNT_MIN)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= CNT_RESET;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bimodal_branch_predictor.sv
// rtl/bimodal_branch_predictor.sv - bimodal direction predictor with a registered lookup
//
// Purpose: a table of 2^INDEX_WIDTH saturating counters indexed by low PC bits. A lookup returns
//          the taken/confident prediction one cycle later. An update trains one entry.
// Ports:
//   clock, resetn          rising-edge clock; asynchronous active-low reset
//   predict_valid/_index   lookup request and entry
//   prediction_valid       high one cycle after predict_valid
//   prediction_taken       counter >= COUNTER_STATES/2 at lookup time
//   prediction_confident   counter at either extreme at lookup time
//   update_valid/_index    resolved-branch update and entry
//   update_taken           1 = increment, 0 = decrement
module bimodal_branch_predictor
  import bimodal_branch_predictor_pkg::*;
#(
  parameter int INDEX_WIDTH    = 4,
  parameter int COUNTER_STATES = 4,
  parameter int COUNTER_RESET  = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   predict_valid,
  input  logic [INDEX_WIDTH-1:0] predict_index,
  output logic                   prediction_valid,
  output logic                   prediction_taken,
  output logic                   prediction_confident,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_taken
);

  localparam int CW    = cnt_width(COUNTER_STATES);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic [CW-1:0] TAKEN_THRESHOLD = CW'(COUNTER_STATES / 2);
  localparam logic [CW-1:0] CNT_MAX         = CW'(COUNTER_STATES - 1);
  localparam logic [CW-1:0] CNT_MIN         = '0;

  logic [CW-1:0] cnt [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic hit;
    assign hit = update_valid && (update_index == INDEX_WIDTH'(gi));

    bimodal_branch_predictor_sat_counter #(
      .WIDTH (COUNTER_STATES),
      .RESET (COUNTER_RESET)
    ) u_cnt (
      .clock       (clock),
      .resetn      (resetn),
      .increment_i (hit &&  update_taken),
      .decrement_i (hit && !update_taken),
      .count_o     (cnt[gi])
    );
  end

  // The read mux sees the counters before this edge's update lands. So a same-index
  // lookup and update is read-before-write, and it needs no bypass.
  logic [CW-1:0] rd_cnt;
  assign rd_cnt = cnt[predict_index];

  logic valid_q, valid_d;
  logic taken_q, taken_d;
  logic conf_q,  conf_d;

  always_comb begin
    valid_d = predict_valid;
    taken_d = taken_q;
    conf_d  = conf_q;
    if (predict_valid) begin
      taken_d = (rd_cnt >= TAKEN_THRESHOLD);
      conf_d  = (rd_cnt == CNT_MIN) || (rd_cnt == CNT_MAX);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      conf_q  <= conf_d;
    end
  end

  assign prediction_valid     = valid_q;
  assign prediction_taken     = taken_q;
  assign prediction_confident = conf_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// tb/tb_bimodal_branch_predictor.sv - directed self-checking bench for the bimodal predictor
module tb_bimodal_branch_predictor;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       predict_valid = 1'b0;
  logic [3:0] predict_index = '0;
  logic       prediction_valid;
  logic       prediction_taken;
  logic       prediction_confident;
  logic       update_valid = 1'b0;
  logic [3:0] update_index = '0;
  logic       update_taken = 1'b0;

  int checks = 0;
  int errors = 0;

  bimodal_branch_predictor #(
    .INDEX_WIDTH    (4),
    .COUNTER_STATES (4),
    .COUNTER_RESET  (1)
  ) dut (
    .clock                (clock),
    .resetn               (resetn),
    .predict_valid        (predict_valid),
    .predict_index        (predict_index),
    .prediction_valid     (prediction_valid),
    .prediction_taken     (prediction_taken),
    .prediction_confident (prediction_confident),
    .update_valid         (update_valid),
    .update_index         (update_index),
    .update_taken         (update_taken)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lookup(input logic [3:0] idx);
    predict_valid = 1'b1;
    predict_index = idx;
    tick();
    predict_valid = 1'b0;
  endtask

  task automatic train(input logic [3:0] idx, input logic tk);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = tk;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic v, input logic t, input logic c);
    chk({tag, ".valid"}, prediction_valid, v);
    chk({tag, ".taken"}, prediction_taken, t);
    chk({tag, ".conf"}, prediction_confident, c);
  endtask

  initial begin
    logic [3:0] post_idx [5];
    post_idx = '{4'd3, 4'd5, 4'd2, 4'd4, 4'd7};

    // 1. reset state, first lookup, idle cycle
    #12;
    expect_pred("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    lookup(4'd0);
    expect_pred("lk0", 1'b1, 1'b0, 1'b0);
    tick();
    expect_pred("idle0", 1'b0, 1'b0, 1'b0);

    // 2. saturate upward at idx 3
    repeat (3) train(4'd3, 1'b1);
    lookup(4'd3);
    expect_pred("sat_up", 1'b1, 1'b1, 1'b1);
    train(4'd3, 1'b1);
    lookup(4'd3);
    expect_pred("sat_up4", 1'b1, 1'b1, 1'b1);

    // 3. saturate downward at idx 5 (no wrap to 3)
    repeat (2) train(4'd5, 1'b0);
    lookup(4'd5);
    expect_pred("sat_dn", 1'b1, 1'b0, 1'b1);

    // 4. same-index lookup + update: pre-update value, then new value
    predict_valid = 1'b1; predict_index = 4'd7;
    update_valid  = 1'b1; update_index  = 4'd7; update_taken = 1'b1;
    tick();
    predict_valid = 1'b0; update_valid = 1'b0;
    expect_pred("rbw7", 1'b1, 1'b0, 1'b0);
    lookup(4'd7);
    expect_pred("after7", 1'b1, 1'b1, 1'b0);

    // different-index lookup + update in the same cycle
    predict_valid = 1'b1; predict_index = 4'd3;
    update_valid  = 1'b1; update_index  = 4'd4; update_taken = 1'b1;
    tick();
    predict_valid = 1'b0; update_valid = 1'b0;
    expect_pred("diff3", 1'b1, 1'b1, 1'b1);
    lookup(4'd4);
    expect_pred("diff4", 1'b1, 1'b1, 1'b0);

    // 5. train idx 2; aliases in the upper bits and the last entry are untouched
    repeat (2) train(4'd2, 1'b1);
    lookup(4'd10);
    expect_pred("idx10", 1'b1, 1'b0, 1'b0);
    lookup(4'd15);
    expect_pred("idx15", 1'b1, 1'b0, 1'b0);
    lookup(4'd2);
    expect_pred("idx2", 1'b1, 1'b1, 1'b1);
    tick();
    expect_pred("hold2", 1'b0, 1'b1, 1'b1);

    // 6. reset during a lookup: outputs drop at once, table returns to cnt 1
    predict_valid = 1'b1; predict_index = 4'd3;
    tick();
    expect_pred("pre_rst", 1'b1, 1'b1, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    expect_pred("mid_rst", 1'b0, 1'b0, 1'b0);
    predict_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lookup(post_idx[i]);
      expect_pred($sformatf("post_rst%0d", post_idx[i]), 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
